// File: rtl/hdl_watchdog_pkg.sv
// Shared watchdog definitions: FSM state encoding and default count width.
package hdl_watchdog_pkg;

  localparam int unsigned DefaultCounterWidth = 32;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRunning = 2'd1,
    StExpired = 2'd2
  } wd_state_e;

endpackage

// File: rtl/hdl_watchdog_if.sv
// Watchdog request/status bundle; master is the controlling side, slave is the watchdog.
interface hdl_watchdog_if
  import hdl_watchdog_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = DefaultCounterWidth
);

  logic [COUNTER_WIDTH-1:0] hdl_timeout_count_;
  logic                     arm;
  logic                     kick;
  logic                     halt;
  logic                     hdl_timeout_;
  logic                     timeout_pulse;
  logic                     running;
  logic [COUNTER_WIDTH-1:0] remaining;

  modport master (
    output hdl_timeout_count_, arm, kick, halt,
    input  hdl_timeout_, timeout_pulse, running, remaining
  );

  modport slave (
    input  hdl_timeout_count_, arm, kick, halt,
    output hdl_timeout_, timeout_pulse, running, remaining
  );

endinterface

// File: rtl/watchdog_prescaler.sv
// Divides clk into watchdog ticks: tick fires on the last of every PRESCALE enabled cycles.
module watchdog_prescaler #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int unsigned CntW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(PRESCALE - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hdl_watchdog.sv
// Watchdog timer: arm/kick/halt requests drive an IDLE/RUNNING/EXPIRED down-counter.
module hdl_watchdog
  import hdl_watchdog_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH = DefaultCounterWidth,
  parameter int unsigned PRESCALE      = 1
) (
  input  logic           clk,
  input  logic           reset_n,
  hdl_watchdog_if.slave  wd
);

  wd_state_e                state_q, state_d;
  logic [COUNTER_WIDTH-1:0] load_q, load_d;
  logic [COUNTER_WIDTH-1:0] remaining_q, remaining_d;
  logic                     timeout_q, timeout_d;
  logic                     pulse_q, pulse_d;
  logic                     tick;
  logic                     presc_enable;
  logic                     presc_clear;

  assign presc_enable = (state_q == StRunning);
  assign presc_clear  = wd.halt | wd.arm | (wd.kick & presc_enable);

  watchdog_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .enable  (presc_enable),
    .clear   (presc_clear),
    .tick    (tick)
  );

  // Priority halt > arm > kick; kick only matters while running.
  always_comb begin
    state_d     = state_q;
    load_d      = load_q;
    remaining_d = remaining_q;
    timeout_d   = timeout_q;
    pulse_d     = 1'b0;
    if (wd.halt) begin
      state_d     = StIdle;
      remaining_d = '0;
      timeout_d   = 1'b0;
    end else if (wd.arm) begin
      load_d      = wd.hdl_timeout_count_;
      remaining_d = wd.hdl_timeout_count_;
      if (wd.hdl_timeout_count_ == '0) begin
        state_d   = StExpired;
        timeout_d = 1'b1;
        pulse_d   = 1'b1;
      end else begin
        state_d   = StRunning;
        timeout_d = 1'b0;
      end
    end else if (state_q == StRunning) begin
      if (wd.kick) begin
        remaining_d = load_q;
      end else if (tick) begin
        if (remaining_q > COUNTER_WIDTH'(1)) begin
          remaining_d = remaining_q - COUNTER_WIDTH'(1);
        end else begin
          // Covers 1 -> 0 and guards against ever wrapping below zero.
          remaining_d = '0;
          state_d     = StExpired;
          timeout_d   = 1'b1;
          pulse_d     = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      load_q      <= '0;
      remaining_q <= '0;
      timeout_q   <= 1'b0;
      pulse_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_q      <= load_d;
      remaining_q <= remaining_d;
      timeout_q   <= timeout_d;
      pulse_q     <= pulse_d;
    end
  end

  assign wd.hdl_timeout_  = timeout_q;
  assign wd.timeout_pulse = pulse_q;
  assign wd.running       = (state_q == StRunning);
  assign wd.remaining     = remaining_q;

endmodule

// File: tb/tb_hdl_watchdog.sv
// Drives three watchdog configurations with shared stimulus and compares against a timing model.
module tb_hdl_watchdog;
  import hdl_watchdog_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        arm, kick, halt;
  logic [31:0] count;

  hdl_watchdog_if #(.COUNTER_WIDTH(DefaultCounterWidth)) if_p1 ();
  hdl_watchdog_if #(.COUNTER_WIDTH(DefaultCounterWidth)) if_p4 ();
  hdl_watchdog_if #(.COUNTER_WIDTH(8))                   if_w8 ();

  assign if_p1.arm = arm;
  assign if_p1.kick = kick;
  assign if_p1.halt = halt;
  assign if_p1.hdl_timeout_count_ = count;
  assign if_p4.arm = arm;
  assign if_p4.kick = kick;
  assign if_p4.halt = halt;
  assign if_p4.hdl_timeout_count_ = count;
  assign if_w8.arm = arm;
  assign if_w8.kick = kick;
  assign if_w8.halt = halt;
  assign if_w8.hdl_timeout_count_ = count[7:0];

  hdl_watchdog #(.COUNTER_WIDTH(DefaultCounterWidth), .PRESCALE(1)) u_dut_p1 (
    .clk(clk), .reset_n(reset_n), .wd(if_p1.slave));
  hdl_watchdog #(.COUNTER_WIDTH(DefaultCounterWidth), .PRESCALE(4)) u_dut_p4 (
    .clk(clk), .reset_n(reset_n), .wd(if_p4.slave));
  hdl_watchdog #(.COUNTER_WIDTH(8), .PRESCALE(1)) u_dut_w8 (
    .clk(clk), .reset_n(reset_n), .wd(if_w8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a running watchdog expires exactly load*prescale edges after its last arm/kick.
  longint presc [3] = '{1, 4, 1};
  longint mask  [3] = '{64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFF};
  string  names [3] = '{"p1", "p4", "w8"};
  longint m_load [3];
  longint m_start[3];
  longint m_exp  [3];
  bit     m_act  [3];
  bit     m_flag [3];
  longint t;

  int n_checks;
  int n_pass;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_load[k] = 0;
      m_act[k]  = 1'b0;
      m_flag[k] = 1'b0;
      m_exp[k]  = -1;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (halt) begin
        m_act[k]  = 1'b0;
        m_flag[k] = 1'b0;
      end else if (arm) begin
        m_load[k] = longint'(count) & mask[k];
        if (m_load[k] == 0) begin
          m_act[k]  = 1'b0;
          m_flag[k] = 1'b1;
          m_exp[k]  = t;
        end else begin
          m_act[k]   = 1'b1;
          m_flag[k]  = 1'b0;
          m_start[k] = t;
        end
      end else if (kick && m_act[k]) begin
        m_start[k] = t;
      end else if (m_act[k] && (t - m_start[k]) >= m_load[k] * presc[k]) begin
        m_act[k]  = 1'b0;
        m_flag[k] = 1'b1;
        m_exp[k]  = t;
      end
    end
  endtask

  task automatic check_inst(input int k);
    longint o_rem, e_rem;
    logic   o_to, o_pu, o_run;
    case (k)
      0: begin
        o_rem = longint'(if_p1.remaining); o_to = if_p1.hdl_timeout_;
        o_pu = if_p1.timeout_pulse; o_run = if_p1.running;
      end
      1: begin
        o_rem = longint'(if_p4.remaining); o_to = if_p4.hdl_timeout_;
        o_pu = if_p4.timeout_pulse; o_run = if_p4.running;
      end
      default: begin
        o_rem = longint'(if_w8.remaining); o_to = if_w8.hdl_timeout_;
        o_pu = if_w8.timeout_pulse; o_run = if_w8.running;
      end
    endcase
    e_rem = m_act[k] ? m_load[k] - (t - m_start[k]) / presc[k] : 0;
    check_eq($sformatf("%s.remaining@%0d", names[k], t), o_rem, e_rem);
    check_eq($sformatf("%s.timeout@%0d", names[k], t), longint'(o_to), longint'(m_flag[k]));
    check_eq($sformatf("%s.pulse@%0d", names[k], t), longint'(o_pu),
             longint'(m_flag[k] && m_exp[k] == t));
    check_eq($sformatf("%s.running@%0d", names[k], t), longint'(o_run), longint'(m_act[k]));
  endtask

  task automatic check_all();
    for (int k = 0; k < 3; k++) check_inst(k);
  endtask

  // Inputs are applied after a falling edge, sampled at the rising edge, checked at the next fall.
  task automatic step(input logic a, input logic k, input logic h, input logic [31:0] c);
    arm = a; kick = k; halt = h; count = c;
    @(posedge clk);
    t++;
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, $urandom);
  endtask

  task automatic async_reset();
    arm = 1'b0; kick = 1'b0; halt = 1'b0;
    #2 reset_n = 1'b0;
    model_clear();
    #1 check_all();
    repeat (2) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    check_all();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    t        = 0;
    reset_n  = 1'b0;
    arm = 1'b0; kick = 1'b0; halt = 1'b0; count = '0;
    model_clear();
    repeat (2) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    check_all();
    reset_n = 1'b1;
    idle(3);

    // Basic expiry, prescaled expiry, kick reload.
    step(1'b1, 1'b0, 1'b0, 32'd5);  idle(8);
    step(1'b0, 1'b0, 1'b1, 32'd0);
    step(1'b1, 1'b0, 1'b0, 32'd3);  idle(14);
    step(1'b1, 1'b0, 1'b0, 32'd10); idle(6);
    step(1'b0, 1'b1, 1'b0, 32'd99); idle(12);

    // Zero count, then arm together with halt.
    step(1'b1, 1'b0, 1'b0, 32'd0);  idle(2);
    step(1'b1, 1'b0, 1'b1, 32'd7);  idle(3);

    // Reset in the middle of a count.
    step(1'b1, 1'b0, 1'b0, 32'd8);  idle(2);
    async_reset();
    idle(10);

    // Full 8-bit range, kick after expiry, re-arm.
    step(1'b1, 1'b0, 1'b0, 32'd255); idle(257);
    step(1'b0, 1'b1, 1'b0, 32'd0);   idle(2);
    step(1'b1, 1'b0, 1'b0, 32'd2);   idle(4);

    // Randomized traffic; count changes every cycle regardless of arm.
    for (int i = 0; i < 1500; i++) begin
      logic a, k, h;
      logic [31:0] c;
      a = ($urandom_range(0, 14) == 0);
      k = ($urandom_range(0, 9) == 0);
      h = ($urandom_range(0, 39) == 0);
      c = ($urandom_range(0, 9) == 0) ? 32'($urandom_range(250, 260))
                                      : 32'($urandom_range(0, 12));
      if ($urandom_range(0, 299) == 0) async_reset();
      else step(a, k, h, c);
    end
    step(1'b0, 1'b0, 1'b1, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hdl_watchdog.md
HDL_WATCHDOG -- requirements
Module: hdl_watchdog

Interface
REQ-001 Parameter COUNTER_WIDTH, default 32: width of the timeout count and down-counter; matches the watchdog_interface count width.
REQ-002 Parameter PRESCALE, default 1, legal range 1..65535: clk cycles per watchdog tick.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 hdl_timeout_count_  input  COUNTER_WIDTH  timeout in ticks, driven by the testbench side of watchdog_interface.
REQ-006 arm  input  1  single-cycle request: latch hdl_timeout_count_ and start counting.
REQ-007 kick  input  1  single-cycle request: reload the counter from the latched count.
REQ-008 halt  input  1  single-cycle request: stop counting and clear timeout.
REQ-009 hdl_timeout_  output  1  active-high sticky timeout flag, sampled by the testbench side of watchdog_interface.
REQ-010 timeout_pulse  output  1  one-cycle pulse on entry to EXPIRED.
REQ-011 running  output  1  high while in RUNNING.
REQ-012 remaining  output  COUNTER_WIDTH  current down-counter value.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, RUNNING and EXPIRED.
REQ-014 Request priority SHALL be halt > arm > kick when several are asserted in the same cycle.
REQ-015 On halt in any state: next state IDLE; remaining, hdl_timeout_ and prescaler cleared.
REQ-016 On arm in any state (no halt): latch hdl_timeout_count_ into a load register; remaining = latched value; prescaler cleared; hdl_timeout_ cleared.
REQ-017 After arm, if the latched value is nonzero, the next state SHALL be RUNNING.
REQ-018 After arm, if the latched value is 0, the next state SHALL be EXPIRED, with hdl_timeout_ and timeout_pulse high one cycle after the arm edge.
REQ-019 The prescaler SHALL count 0..PRESCALE-1 only in RUNNING; tick = prescaler at PRESCALE-1, then it wraps to 0.
REQ-020 With PRESCALE=1, tick SHALL be high on every RUNNING cycle.
REQ-021 In RUNNING, on a tick with remaining > 1: remaining decrements by 1.
REQ-022 In RUNNING, on a tick with remaining == 1: remaining becomes 0, state becomes EXPIRED, hdl_timeout_ is set and timeout_pulse is high for exactly that cycle.
REQ-023 Latency: with arm at edge E and latched count N > 0, hdl_timeout_ SHALL rise at edge E + N*PRESCALE.
REQ-024 kick in RUNNING (no arm or halt): remaining reloads from the load register and the prescaler clears; the count is not decremented in that cycle.
REQ-025 kick in IDLE or EXPIRED SHALL be ignored.
REQ-026 hdl_timeout_ SHALL remain high in EXPIRED until halt, arm or reset.
REQ-027 Changes on hdl_timeout_count_ SHALL have no effect except in a cycle where arm is accepted.
REQ-028 Decrement SHALL never wrap below 0.
REQ-029 A count of all-ones SHALL be legal and SHALL count the full range.

Reset
REQ-030 reset_n low SHALL immediately force: state IDLE, load register 0, remaining 0, prescaler 0, hdl_timeout_ 0, timeout_pulse 0, running 0.
REQ-031 Reset asserted mid-count SHALL abort the count; no timeout_pulse SHALL be emitted.
REQ-032 After reset_n deasserts, the block SHALL stay in IDLE until the first arm.

Structure
REQ-033 The FSM state enum and the default COUNTER_WIDTH constant SHALL live in a shared watchdog package, imported by the RTL and the testbench.
REQ-034 The prescaler SHALL be a separate sub-module, watchdog_prescaler (inputs: enable, clear; output: tick).
REQ-035 All other logic SHALL be in hdl_watchdog.

Verification
REQ-036 PRESCALE=1, arm with count=5 -> running high after edge E; hdl_timeout_ and timeout_pulse rise at E+5; pulse is 1 cycle; flag stays high.
REQ-037 PRESCALE=4, count=3 -> timeout at E+12; remaining steps 3,2,1,0 every 4 cycles.
REQ-038 PRESCALE=1, count=10, kick at E+7 -> remaining=10 at E+8; timeout at E+17.
REQ-039 arm with count=0 -> EXPIRED and hdl_timeout_ high at E+1; arm+halt in the same cycle -> IDLE, no timeout.
REQ-040 reset_n pulsed low at E+3 during count=8 -> all outputs 0 immediately; no timeout after release until re-armed.
REQ-041 COUNTER_WIDTH=8, count=255, kick in EXPIRED ignored -> timeout at E+255; re-arm with count=2 clears the flag; timeout again 2 cycles later.
